// File: rtl/sonar_scheduler.sv
// Round-robin sonar firing scheduler: fires each enabled channel in turn, latches its distance, then waits a guard gap.
// Optional ready watchdog enabled by defining SONAR_SCHED_TIMEOUT_EN.
module sonar_scheduler #(
    parameter int freq           = 50_000_000,
    parameter int N_SONARS       = 4,
    parameter int GUARD_CYCLES   = freq / 50,
    parameter int TIMEOUT_CYCLES = freq / 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [N_SONARS-1:0]   chan_mask,
    output logic [N_SONARS-1:0]   measure,
    input  logic [N_SONARS-1:0]   sonar_ready,
    input  logic [8*N_SONARS-1:0] sonar_dist,
    output logic [8*N_SONARS-1:0] distances,
    output logic [N_SONARS-1:0]   valid,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int CH_W = (N_SONARS > 1) ? $clog2(N_SONARS) : 1;
    localparam logic [31:0] GUARD_LAST = 32'(GUARD_CYCLES - 1);
`ifdef SONAR_SCHED_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
`endif

    if (freq < 1 || N_SONARS < 1 || N_SONARS > 8 || GUARD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("sonar_scheduler: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, FIRE, WAIT_READY, GUARD, DONE} state_t;

    state_t              state;
    logic [N_SONARS-1:0] mask_q;
    logic [N_SONARS-1:0] ready_q;
    logic [CH_W-1:0]     ch;
    logic [31:0]         cnt;
    logic                ready_edge;
    logic [CH_W:0]       first_ch;
    logic [CH_W:0]       next_ch;

    // Returns {found, index} of the lowest set bit of m at or above position from.
    function automatic logic [CH_W:0] find_chan(input logic [N_SONARS-1:0] m, input int from);
        find_chan = '0;
        for (int i = N_SONARS - 1; i >= 0; i--) begin
            if (m[i] && i >= from) find_chan = {1'b1, i[CH_W-1:0]};
        end
    endfunction

    assign ready_edge = sonar_ready[ch] & ~ready_q[ch];
    assign first_ch   = find_chan(chan_mask, 0);
    assign next_ch    = find_chan(mask_q, int'(ch) + 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mask_q     <= '0;
            ready_q    <= '0;
            ch         <= '0;
            cnt        <= '0;
            measure    <= '0;
            distances  <= '0;
            valid      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            ready_q    <= sonar_ready;
            measure    <= '0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || continuous) begin
                        mask_q <= chan_mask;
                        valid  <= '0;
                        busy   <= 1'b1;
                        if (first_ch[CH_W]) begin
                            ch    <= first_ch[CH_W-1:0];
                            state <= FIRE;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                FIRE: begin
                    measure[ch] <= 1'b1;
                    cnt         <= '0;
                    state       <= WAIT_READY;
                end
                WAIT_READY: begin
                    // Only a fresh rising edge counts; a level left high by the driver is stale.
                    if (ready_edge) begin
                        distances[8*ch +: 8] <= sonar_dist[8*ch +: 8];
                        valid[ch]            <= 1'b1;
                        cnt                  <= '0;
                        state                <= GUARD;
                    end
`ifdef SONAR_SCHED_TIMEOUT_EN
                    else if (cnt == TIMEOUT_LAST) begin
                        distances[8*ch +: 8] <= 8'hFF;
                        valid[ch]            <= 1'b0;
                        cnt                  <= '0;
                        state                <= GUARD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
`endif
                end
                GUARD: begin
                    if (cnt == GUARD_LAST) begin
                        cnt <= '0;
                        if (next_ch[CH_W]) begin
                            ch    <= next_ch[CH_W-1:0];
                            state <= FIRE;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sonar_scheduler.sv
// Self-checking bench for sonar_scheduler: driver models per channel, a frame-level reference model, directed scenarios and a random phase.
module tb_sonar_scheduler;
    localparam int N = 4;
    localparam int G = 10;
    localparam int T = 100;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           continuous = 1'b0;
    logic [N-1:0]   chan_mask = '0;
    logic [N-1:0]   measure;
    logic [N-1:0]   sonar_ready;
    logic [N-1:0]   ready_r = '0;
    logic [N-1:0]   hold = '0;
    logic [8*N-1:0] sonar_dist = '0;
    logic [8*N-1:0] distances;
    logic [N-1:0]   valid;
    logic           busy;
    logic           frame_done;

    assign sonar_ready = ready_r | hold;

    always #5 clk = ~clk;

    sonar_scheduler #(.N_SONARS(N), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .chan_mask(chan_mask), .measure(measure), .sonar_ready(sonar_ready),
        .sonar_dist(sonar_dist), .distances(distances), .valid(valid),
        .busy(busy), .frame_done(frame_done)
    );

    // Sonar driver models: ready drops on measure, rises after a delay (0 = never) with the new distance.
    int         cfg_dly [N];
    logic [7:0] cfg_val [N];
    bit         rand_mode = 1'b0;
    int         drv_t   [N];
    int         drv_dly [N];
    logic [7:0] drv_val [N];
    bit         drv_act [N];

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < N; k++) begin
            if (measure[k]) begin
                drv_act[k] = 1'b1;
                drv_t[k]   = 0;
                ready_r[k] = 1'b0;
                sonar_dist[8*k +: 8] = 8'hEE;
                if (rand_mode) begin
`ifdef SONAR_SCHED_TIMEOUT_EN
                    drv_dly[k] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
`else
                    drv_dly[k] = int'($urandom_range(1, 40));
`endif
                    drv_val[k] = 8'($urandom);
                end else begin
                    drv_dly[k] = cfg_dly[k];
                    drv_val[k] = cfg_val[k];
                end
            end else if (drv_act[k]) begin
                drv_t[k]++;
                if (drv_dly[k] > 0 && drv_t[k] == drv_dly[k]) begin
                    ready_r[k] = 1'b1;
                    sonar_dist[8*k +: 8] = drv_val[k];
                    drv_act[k] = 1'b0;
                end
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: tracks the frame as events (start, fire, capture, timeout, done) with their cycle times.
    bit         synced = 1'b0;
    bit         rst_prev = 1'b0;
    bit         in_frame = 1'b0;
    bit         saw_done = 1'b0;
    logic [N-1:0] mask_m = '0;
    logic [N-1:0] valid_m = '0;
    logic [N-1:0] ready_prev = '0;
    logic [7:0] bank [N];
    int         w = -1;
    int         due = -1;
    int         kind = 0;
    int         meas_cyc = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         meas_log [$];

    function automatic int next_en(input logic [N-1:0] m, input int from);
        for (int i = from; i < N; i++) if (m[i]) return i;
        return -2;
    endfunction

    task automatic model_step();
        logic [N-1:0]   exp_meas;
        logic [8*N-1:0] exp_dist;
        bit             exp_done;
        cyc++;
        saw_done = 1'b0;
        if (rst_prev) begin
            chk("reset_measure", 64'(measure), 64'd0);
            chk("reset_distances", 64'(distances), 64'd0);
            chk("reset_valid", 64'(valid), 64'd0);
            chk("reset_busy", 64'(busy), 64'd0);
            chk("reset_frame_done", 64'(frame_done), 64'd0);
            in_frame = 1'b0;
            valid_m  = '0;
            w        = -1;
            due      = -1;
            for (int k = 0; k < N; k++) bank[k] = 8'h00;
            synced = 1'b1;
        end else if (synced) begin
            exp_meas = '0;
            exp_done = 1'b0;
            if (due == cyc) begin
                if (kind >= 0) begin
                    exp_meas[kind] = 1'b1;
                    w = kind;
                    meas_cyc = cyc;
                end else begin
                    exp_done = 1'b1;
                    in_frame = 1'b0;
                end
                due = -1;
            end
            for (int k = 0; k < N; k++) exp_dist[8*k +: 8] = bank[k];
            chk("measure", 64'(measure), 64'(exp_meas));
            chk("frame_done", 64'(frame_done), 64'(exp_done));
            chk("busy", 64'(busy), 64'(in_frame));
            chk("valid", 64'(valid), 64'(valid_m));
            chk("distances", 64'(distances), 64'(exp_dist));
        end
        for (int k = 0; k < N; k++) if (measure[k]) meas_log.push_back(k);
        if (frame_done === 1'b1) begin
            saw_done = 1'b1;
            done_cnt++;
        end
        rst_prev = rst;
        if (!rst && synced) begin
            if (w >= 0 && sonar_ready[w] && !ready_prev[w]) begin
                bank[w]    = sonar_dist[8*w +: 8];
                valid_m[w] = 1'b1;
                due  = cyc + G + 2;
                kind = next_en(mask_m, w + 1);
                w    = -1;
            end
`ifdef SONAR_SCHED_TIMEOUT_EN
            else if (w >= 0 && cyc - meas_cyc == T - 1) begin
                bank[w] = 8'hFF;
                due  = cyc + G + 2;
                kind = next_en(mask_m, w + 1);
                w    = -1;
            end
`endif
            if (!in_frame && (start || continuous)) begin
                in_frame = 1'b1;
                mask_m   = chan_mask;
                valid_m  = '0;
                due  = cyc + 2;
                kind = next_en(chan_mask, 0);
            end
        end
        ready_prev = sonar_ready;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int max);
        bit got = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (saw_done) begin
                got = 1'b1;
                break;
            end
        end
        chk(name, 64'(got), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no end of run, expected finish before 2 ms");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        int n0;
        int steps;
        for (int k = 0; k < N; k++) begin
            cfg_dly[k] = 20;
            cfg_val[k] = 8'(8'h11 * (k + 1));
            bank[k]    = 8'h00;
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Full mask, distances 11/22/33/44
        meas_log.delete();
        n0 = done_cnt;
        chan_mask = 4'b1111;
        pulse_start();
        wait_done("s1_frame_done", 1000);
        repeat (5) tick();
        chk("s1_pulse_count", 64'(meas_log.size()), 64'd4);
        for (int i = 0; i < meas_log.size() && i < 4; i++) chk("s1_order", 64'(meas_log[i]), 64'(i));
        chk("s1_distances", 64'(distances), 64'h44332211);
        chk("s1_valid", 64'(valid), 64'hF);
        chk("s1_done_pulses", 64'(done_cnt - n0), 64'd1);

        // Partial mask; mask change and start pulse mid-frame have no effect
        for (int k = 0; k < N; k++) cfg_val[k] = 8'(8'h55 + 8'h11 * k);
        meas_log.delete();
        chan_mask = 4'b0101;
        pulse_start();
        repeat (30) tick();
        chan_mask = 4'b1111;
        pulse_start();
        wait_done("s2_frame_done", 1000);
        repeat (40) tick();
        chk("s2_pulse_count", 64'(meas_log.size()), 64'd2);
        if (meas_log.size() >= 2) begin
            chk("s2_first", 64'(meas_log[0]), 64'd0);
            chk("s2_second", 64'(meas_log[1]), 64'd2);
        end
        chk("s2_distances", 64'(distances), 64'h44772255);
        chk("s2_valid", 64'(valid), 64'b0101);
        chk("s2_idle_busy", 64'(busy), 64'd0);

        // Empty mask: done within 3 cycles, no fire
        meas_log.delete();
        chan_mask = 4'b0000;
        pulse_start();
        steps = 0;
        for (int i = 0; i < 3 && !saw_done; i++) begin
            tick();
            steps++;
        end
        chk("s3_done_in_3", 64'(saw_done), 64'd1);
        repeat (5) tick();
        chk("s3_no_measure", 64'(meas_log.size()), 64'd0);
        chk("s3_valid", 64'(valid), 64'd0);
        chk("s3_distances_kept", 64'(distances), 64'h44772255);

        // Stale ready level on channel 0 must not capture
        cfg_val[0] = 8'h5A;
        hold[0] = 1'b1;
        repeat (3) tick();
        meas_log.delete();
        chan_mask = 4'b0001;
        pulse_start();
        for (int i = 0; i < 10 && meas_log.size() == 0; i++) tick();
        chk("s4_fired", 64'(meas_log.size()), 64'd1);
        repeat (5) tick();
        chk("s4_no_early_capture", 64'(valid), 64'd0);
        hold[0] = 1'b0;
        wait_done("s4_frame_done", 1000);
        chk("s4_dist0", 64'(distances[7:0]), 64'h5A);
        chk("s4_valid", 64'(valid), 64'b0001);

`ifdef SONAR_SCHED_TIMEOUT_EN
        // Channel 2 never answers
        cfg_dly[2] = 0;
        meas_log.delete();
        chan_mask = 4'b1111;
        pulse_start();
        wait_done("s5_frame_done", 2000);
        chk("s5_dist2", 64'(distances[23:16]), 64'hFF);
        chk("s5_valid", 64'(valid), 64'b1011);
        chk("s5_ch3_fired", 64'(meas_log.size()), 64'd4);
        cfg_dly[2] = 20;
`endif

        // Continuous mode, reset mid-WAIT_READY
        meas_log.delete();
        chan_mask = 4'b1111;
        continuous = 1'b1;
        for (int i = 0; i < 10 && meas_log.size() == 0; i++) tick();
        chk("s6_fired", 64'(meas_log.size()), 64'd1);
        repeat (8) tick();
        n0 = done_cnt;
        rst = 1'b1;
        tick();
        chk("s6_rst_measure", 64'(measure), 64'd0);
        chk("s6_rst_distances", 64'(distances), 64'd0);
        chk("s6_rst_valid", 64'(valid), 64'd0);
        chk("s6_rst_busy", 64'(busy), 64'd0);
        chk("s6_rst_done", 64'(frame_done), 64'd0);
        rst = 1'b0;
        tick();
        chk("s6_restart_busy", 64'(busy), 64'd1);
        chk("s6_no_done_on_rst", 64'(done_cnt - n0), 64'd0);
        continuous = 1'b0;
        wait_done("s6_frame_done", 1000);

        // Random phase
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 199) == 0) continuous = ~continuous;
            if ($urandom_range(0, 59) == 0) chan_mask = 4'($urandom);
            rst = ($urandom_range(0, 1499) == 0);
            tick();
        end
        start = 1'b0;
        rst = 1'b0;
        continuous = 1'b0;
        repeat (300) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
